// File: rtl/mod14_mon_pkg.sv
// Shared types for the Mod-14 transition monitor: event codes and the queued event record.
package mod14_mon_pkg;

  localparam logic [3:0] MOD_MAX = 4'd13;

  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    EV_INC     = 3'd1,
    EV_DEC     = 3'd2,
    EV_WRAP_UP = 3'd3,
    EV_WRAP_DN = 3'd4,
    EV_JUMP    = 3'd5,
    EV_ILLEGAL = 3'd6
  } evt_e;

  typedef struct packed {
    evt_e       typ;
    logic [3:0] cnt;
  } evt_rec_t;

endpackage

// File: rtl/mod14_evt_fifo.sv
// Synchronous event FIFO with a registered head; a push is accepted when full if a pop
// happens in the same cycle.
module mod14_evt_fifo
  import mod14_mon_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     push,
  input  logic     pop,
  input  evt_rec_t din,
  output logic     full,
  output logic     head_vld,
  output evt_rec_t head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  evt_rec_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after_pop;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign full = (count == CNT_W'(FIFO_DEPTH));

  always_comb begin
    do_pop          = pop && head_vld;
    do_push         = push && (!full || do_pop);
    rd_nxt          = rd_ptr + PTR_W'(do_pop);
    count_after_pop = count - CNT_W'(do_pop);
    count_nxt       = count_after_pop + CNT_W'(do_push);
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  // Head is the next occupant after this cycle's pop: the incoming record if the
  // FIFO would otherwise be empty, else the stored entry at the advanced read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
      head     <= '0;
    end else if (clr) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
      head     <= '0;
    end else begin
      rd_ptr   <= rd_nxt;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      count    <= count_nxt;
      head_vld <= (count_nxt != '0);
      if (count_nxt != '0) head <= (count_after_pop == '0) ? din : mem[rd_nxt];
    end
  end

endmodule

// File: rtl/mod14_transition_monitor.sv
// Observes a Mod-14 counter, classifies each sampled change, tallies wraps and queues
// event records for a valid/ready consumer.
module mod14_transition_monitor
  import mod14_mon_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mon_en,
  input  logic [3:0]               cnt_in,
  input  logic                     clr,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [2:0]               evt_type,
  output logic [3:0]               evt_cnt,
  output logic signed [WRAP_W-1:0] wrap_tally,
  output logic                     illegal,
  output logic                     overflow
);

  logic [3:0] prev_q;
  logic       prev_vld;
  evt_e       typ;
  logic       sample;
  logic       legal;
  logic       classify_en;
  logic       push;
  logic       pop;
  logic       fifo_full;
  evt_rec_t   rec;
  evt_rec_t   head;

  function automatic logic signed [WRAP_W-1:0] tally_step(
    input logic signed [WRAP_W-1:0] t,
    input evt_e                     e
  );
    logic signed [WRAP_W-1:0] r;
    r = t;
    if (e == EV_WRAP_UP)      r = t + WRAP_W'(1);
    else if (e == EV_WRAP_DN) r = t - WRAP_W'(1);
    return r;
  endfunction

  always_comb begin
    typ = EV_NONE;
    if (cnt_in > MOD_MAX)                               typ = EV_ILLEGAL;
    else if (cnt_in == prev_q)                          typ = EV_NONE;
    else if (prev_q == MOD_MAX && cnt_in == 4'd0)       typ = EV_WRAP_UP;
    else if (prev_q == 4'd0 && cnt_in == MOD_MAX)       typ = EV_WRAP_DN;
    else if ({1'b0, cnt_in} == {1'b0, prev_q} + 5'd1)   typ = EV_INC;
    else if ({1'b0, cnt_in} + 5'd1 == {1'b0, prev_q})   typ = EV_DEC;
    else                                                typ = EV_JUMP;
  end

  assign sample      = mon_en && !clr;
  assign legal       = (cnt_in <= MOD_MAX);
  assign classify_en = sample && prev_vld;
  assign push        = classify_en && (typ != EV_NONE);
  assign pop         = evt_valid && evt_ready;
  assign rec         = '{typ: typ, cnt: cnt_in};

  // Illegal samples never become the reference, so the next legal value is judged
  // against the last legal one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= 4'd0;
      prev_vld   <= 1'b0;
      wrap_tally <= '0;
      illegal    <= 1'b0;
      overflow   <= 1'b0;
    end else if (clr) begin
      prev_q     <= 4'd0;
      prev_vld   <= 1'b0;
      wrap_tally <= '0;
      illegal    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (sample && legal) begin
        prev_q   <= cnt_in;
        prev_vld <= 1'b1;
      end
      if (classify_en) wrap_tally <= tally_step(wrap_tally, typ);
      if (sample && !legal) illegal <= 1'b1;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  mod14_evt_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (push),
    .pop      (pop),
    .din      (rec),
    .full     (fifo_full),
    .head_vld (evt_valid),
    .head     (head)
  );

  assign evt_type = head.typ;
  assign evt_cnt  = head.cnt;

endmodule
